dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the hart's data-memory port, for the phase that replaces the combinational dmem model with a realistic memory.
- Accepts one word-aligned, byte-masked read or write request via a valid/ready handshake.
- Performs the access against internal word storage.
- Returns a one-cycle response pulse a fixed, parameterised number of cycles later; only one request is outstanding at a time.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage (power of two).
- BASE_ADDR, 32'h00000000: byte address of word 0.
- LATENCY, 2: clock edges from request acceptance to response-valid; legal range 1..15.

Ports:
- i_clk  input  1  global clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  responder can accept a request this cycle.
- i_req_addr  input  32  byte address; must be word aligned.
- i_req_ren  input  1  read request.
- i_req_wen  input  1  write request.
- i_req_wdata  input  32  write data, already shifted into its byte lanes.
- i_req_mask  input  4  byte-lane enables; bit k covers bits [8k+7:8k].
- o_rsp_valid  output  1  response pulse, exactly one cycle.
- o_rsp_rdata  output  32  read data; masked-off lanes are 0.
- o_rsp_err  output  1  request was rejected (see errors); qualified by o_rsp_valid.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, latency counter=0.
- Storage contents are not reset; they survive i_rst.
- States: IDLE, BUSY, RESP.
- IDLE:
  - o_req_ready=1.
  - On an edge with i_req_valid=1, capture addr, ren, wen, wdata and mask, load counter with LATENCY-1, and go to BUSY.
  - i_req_valid=0 means stay in IDLE.
- BUSY:
  - o_req_ready=0 and i_req_valid is ignored.
  - On each edge: if counter!=0, decrement it.
  - If counter==0, perform the access (commit edge) and go to RESP.
- Commit edge, legal request:
  - Write: storage[idx] lanes with mask=1 take the wdata lanes; other lanes are unchanged.
  - Read: o_rsp_rdata = storage[idx] with lanes where mask=0 forced to 0.
  - Write response: o_rsp_rdata=0.
  - o_rsp_err=0.
- RESP:
  - o_rsp_valid=1 and o_req_ready=0.
  - On the next edge go to IDLE and clear o_rsp_valid.
  - o_rsp_rdata and o_rsp_err hold until the next commit.
- Timing: acceptance at edge E0 means o_rsp_valid is high in the cycle after edge E(LATENCY). o_req_ready returns high after edge E(LATENCY+1). Maximum throughput is 1 request per LATENCY+2 cycles.
- Index: idx = (addr - BASE_ADDR) >> 2, using unsigned 32-bit subtraction.
- Errors, checked on captured values at the commit edge. Any error means no storage write, rdata=0, err=1, with the same latency as a legal request:
  - addr[1:0] != 0;
  - ren and wen both 1;
  - ren and wen both 0;
  - addr < BASE_ADDR;
  - idx >= DEPTH_WORDS;
  - mask == 0.
- Read-after-write: a read accepted after a write's response observes that write.
- Reset mid-operation:
  - Reset in BUSY, before the commit edge: the request is dropped with no storage change and no response.
  - Reset in RESP: o_rsp_valid deasserts immediately (asynchronously).
- Request signals may change freely while o_req_ready=0; they are sampled only at the acceptance edge.

Test Plan:
1. LATENCY=2, reset, then write addr 0x10 wdata 0xDEADBEEF mask 1111; then read 0x10 mask 1111 -> each o_rsp_valid is high exactly in the cycle after the 2nd edge following acceptance; read returns 0xDEADBEEF, err=0.
2. Write 0x20 = 0x11223344 mask 1111; write 0x20 wdata 0xAA000000 mask 1000; read mask 1111 -> 0xAA223344; read mask 0011 -> 0x00003344.
3. Read 0x22 -> err=1, rdata=0. Write 0x24 with ren=wen=1 -> err=1; a following read of 0x24 shows old contents. Read addr BASE+4*DEPTH_WORDS -> err=1.
4. Hold i_req_valid=1 with 3 queued reads -> o_req_ready low during BUSY/RESP; exactly 3 responses, one every LATENCY+2=4 cycles; no request lost or duplicated.
5. Accept a write of 0x55555555 to 0x30 (prior value 0x0); assert i_rst 1 cycle after acceptance (before commit); release; read 0x30 -> 0x00000000, and no response for the aborted write.
6. LATENCY=1 build: accept a read at E0 -> o_rsp_valid high in the cycle after E1, o_req_ready high again after E2.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory end of the hart's data-memory port. Accepts one word-aligned,
// byte-masked read or write per valid/ready handshake, performs it against
// internal word storage after a fixed LATENCY, and returns a single-cycle
// response pulse. Only one request is outstanding at a time.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage (power of two)
//   BASE_ADDR    byte address of word 0
//   LATENCY      clock edges from acceptance to response-valid (1..15)
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset (storage is not reset)
//   i_req_valid  request present
//   o_req_ready  responder can accept a request this cycle
//   i_req_addr   byte address (word aligned)
//   i_req_ren    read request
//   i_req_wen    write request
//   i_req_wdata  write data, already placed in its byte lanes
//   i_req_mask   byte-lane enables, bit k covers bits [8k+7:8k]
//   o_rsp_valid  one-cycle response pulse
//   o_rsp_rdata  read data, disabled lanes read as 0; held until next commit
//   o_rsp_err    request rejected; qualified by o_rsp_valid
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        commit;

    // Request fields captured at the acceptance edge.
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        ren_reg;
    logic        wen_reg;
    logic [3:0]  mask_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic [AW-1:0] mem_idx;
    logic        req_err;
    logic [31:0] lane_bits;

    // Unsigned wrap on the subtraction is harmless: addresses below the base
    // are rejected by their own comparison.
    assign offset   = addr_reg - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign mem_idx  = word_idx[AW-1:0];

    assign req_err = (addr_reg[1:0] != 2'b00)
                   || (ren_reg == wen_reg)
                   || (addr_reg < BASE_ADDR)
                   || (word_idx >= 32'(DEPTH_WORDS))
                   || (mask_reg == 4'b0000);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bits[8*gi +: 8] = {8{mask_reg[gi]}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: next state, counter and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        commit      = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_next = BUSY;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Driven from state so an async reset drops it immediately.
                o_rsp_valid = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (commit) begin
                err_reg <= req_err;
                if (req_err || wen_reg) begin
                    rdata_reg <= 32'd0;
                end else begin
                    rdata_reg <= mem[mem_idx] & lane_bits;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture registers and storage: no reset, contents survive i_rst.
    // commit is forced low while reset holds the FSM in IDLE, so an
    // aborted request never reaches the array.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (state_reg == IDLE && i_req_valid) begin
            addr_reg  <= i_req_addr;
            wdata_reg <= i_req_wdata;
            ren_reg   <= i_req_ren;
            wen_reg   <= i_req_wen;
            mask_reg  <= i_req_mask;
        end
        if (commit && !req_err && wen_reg) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_reg[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
                end
            end
        end
    end

    assign o_rsp_rdata = rdata_reg;
    assign o_rsp_err   = err_reg;

endmodule
